// File: rtl/bb_sym_pkg.sv
// rtl/bb_sym_pkg.sv - shared mode encodings, FIFO entry layout and FSM states for the tx symbol packer
package bb_sym_pkg;

  localparam logic [1:0] MODE_GFSK  = 2'd0;
  localparam logic [1:0] MODE_DQPSK = 2'd1;
  localparam logic [1:0] MODE_D8PSK = 2'd2;

  // Widest symbol any supported mode produces (8DPSK).
  localparam int SYM_BITS = 3;

  typedef struct packed {
    logic [SYM_BITS-1:0] data;
    logic [1:0]          nbits;
    logic                guard;
    logic                last;
  } sym_entry_t;

  typedef enum logic [1:0] {IDLE, RUN, GUARD} state_t;

  // Reserved mode 3 falls into the default and behaves as GFSK.
  function automatic logic [1:0] bps(input logic [1:0] m);
    case (m)
      MODE_DQPSK: return 2'd2;
      MODE_D8PSK: return 2'd3;
      default:    return 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/sym_fifo.sv
// rtl/sym_fifo.sv - synchronous symbol FIFO with wrap-bit full/empty and in-place guard clear of the head
module sym_fifo
  import bb_sym_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rstz,
  input  logic       push,
  input  sym_entry_t wdata,
  input  logic       pop,
  input  logic       clr_guard,
  output sym_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  sym_entry_t  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal only when a pop frees the slot in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstz) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (clr_guard) begin
        mem[rd_ptr[AW-1:0]].guard <= 1'b0;
      end
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/txsym_packer.sv
// rtl/txsym_packer.sv - packs the serial tx bit stream into 1/2/3-bit modulation symbols released per sym_tick
module txsym_packer
  import bb_sym_pkg::*;
#(
  parameter int MAXBPS    = 3,
  parameter int DEPTH     = 8,
  parameter int GUARD_SYM = 5
) (
  input  logic              clk_6M,
  input  logic              rstz,
  input  logic              in_bit,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic [1:0]        mode,
  input  logic              mode_load,
  input  logic              sym_tick,
  output logic              in_ready,
  output logic [MAXBPS-1:0] sym_out,
  output logic [1:0]        sym_nbits,
  output logic              sym_valid,
  output logic              guard_active,
  output logic              busy,
  output logic              ovf,
  output logic              underrun,
  output logic              proto_err
);

  localparam int GW = $clog2(GUARD_SYM + 2);

  state_t              state;
  state_t              state_d;
  logic [SYM_BITS-1:0] acc;
  logic [SYM_BITS-1:0] acc_d;
  logic [SYM_BITS-1:0] acc_shift;
  logic [1:0]          acc_cnt;
  logic [1:0]          acc_cnt_d;
  logic [1:0]          cnt_inc;
  logic [1:0]          cur_mode;
  logic                pend_guard;
  logic [GW-1:0]       gcnt;

  logic                push_req;
  logic                push_ok;
  logic                pop;
  logic                clr_guard;
  sym_entry_t          push_entry;
  sym_entry_t          head;
  logic                full;
  logic                empty;

  sym_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk_6M),
    .rstz      (rstz),
    .push      (push_req),
    .wdata     (push_entry),
    .pop       (pop),
    .clr_guard (clr_guard),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // full comes straight from the pointer flops, so in_ready is registered.
  assign in_ready = !full;
  assign push_ok  = push_req && (!full || pop);

  always_comb begin : accumulate
    acc_shift  = acc | (SYM_BITS'(in_bit) << acc_cnt);
    cnt_inc    = acc_cnt + 2'd1;
    acc_d      = acc;
    acc_cnt_d  = acc_cnt;
    push_req   = 1'b0;
    push_entry = '{data: acc, nbits: acc_cnt, guard: pend_guard, last: 1'b0};
    if (mode_load) begin
      // Flush a partial symbol under the old mode; a coincident bit is dropped.
      if (acc_cnt != 2'd0) begin
        push_req  = 1'b1;
        acc_d     = '0;
        acc_cnt_d = 2'd0;
      end
    end else if (in_valid) begin
      if (cnt_inc == bps(cur_mode) || in_last) begin
        push_req   = 1'b1;
        push_entry = '{data: acc_shift, nbits: cnt_inc, guard: pend_guard, last: in_last};
        acc_d      = '0;
        acc_cnt_d  = 2'd0;
      end else begin
        acc_d     = acc_shift;
        acc_cnt_d = cnt_inc;
      end
    end
  end

  always_comb begin : fsm
    state_d   = state;
    pop       = 1'b0;
    clr_guard = 1'b0;
    case (state)
      IDLE: begin
        if (push_req || !empty) state_d = RUN;
      end
      RUN: begin
        if (sym_tick && !empty) begin
          if (head.guard && GUARD_SYM > 0) begin
            state_d = GUARD;
          end else begin
            pop = 1'b1;
            if (head.last) state_d = IDLE;
          end
        end
      end
      GUARD: begin
        if (sym_tick && gcnt == GW'(1)) begin
          clr_guard = 1'b1;
          state_d   = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      state        <= IDLE;
      acc          <= '0;
      acc_cnt      <= 2'd0;
      cur_mode     <= MODE_GFSK;
      pend_guard   <= 1'b0;
      gcnt         <= '0;
      sym_out      <= '0;
      sym_nbits    <= 2'd0;
      sym_valid    <= 1'b0;
      guard_active <= 1'b0;
      busy         <= 1'b0;
      ovf          <= 1'b0;
      underrun     <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      state     <= state_d;
      acc       <= acc_d;
      acc_cnt   <= acc_cnt_d;
      sym_valid <= pop;
      ovf       <= push_req && !push_ok;
      underrun  <= (state == RUN) && sym_tick && empty;
      proto_err <= mode_load && in_valid;

      if (push_ok && push_entry.guard) pend_guard <= 1'b0;
      if (mode_load) begin
        cur_mode <= mode;
        if (bps(cur_mode) == 2'd1 && (mode == MODE_DQPSK || mode == MODE_D8PSK))
          pend_guard <= 1'b1;
      end

      if (pop) begin
        sym_out   <= MAXBPS'(head.data);
        sym_nbits <= head.nbits;
      end

      if (state == RUN && state_d == GUARD) begin
        gcnt         <= GW'(GUARD_SYM);
        guard_active <= 1'b1;
      end else if (state == GUARD && sym_tick) begin
        gcnt <= gcnt - GW'(1);
        if (clr_guard) guard_active <= 1'b0;
      end

      if (state == IDLE && state_d == RUN) busy <= 1'b1;
      else if (pop && head.last)           busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_txsym_packer.sv
// tb/tb_txsym_packer.sv - directed table-driven bench for txsym_packer
module tb_txsym_packer;

  localparam int MAXBPS    = 3;
  localparam int DEPTH     = 8;
  localparam int GUARD_SYM = 5;

  logic              clk_6M = 1'b0;
  logic              rstz = 1'b0;
  logic              in_bit = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic              mode_load = 1'b0;
  logic              sym_tick = 1'b0;
  logic              in_ready;
  logic [MAXBPS-1:0] sym_out;
  logic [1:0]        sym_nbits;
  logic              sym_valid;
  logic              guard_active;
  logic              busy;
  logic              ovf;
  logic              underrun;
  logic              proto_err;

  txsym_packer #(.MAXBPS(MAXBPS), .DEPTH(DEPTH), .GUARD_SYM(GUARD_SYM)) dut (
    .clk_6M       (clk_6M),
    .rstz         (rstz),
    .in_bit       (in_bit),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .mode         (mode),
    .mode_load    (mode_load),
    .sym_tick     (sym_tick),
    .in_ready     (in_ready),
    .sym_out      (sym_out),
    .sym_nbits    (sym_nbits),
    .sym_valid    (sym_valid),
    .guard_active (guard_active),
    .busy         (busy),
    .ovf          (ovf),
    .underrun     (underrun),
    .proto_err    (proto_err)
  );

  always #5 clk_6M = ~clk_6M;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] mode;
    int         nbit;
    logic [7:0] bits;
    int         nsym;
    logic [8:0] syms;
    logic [5:0] nb;
    int         gap;
  } vec_t;

  vec_t vecs [4];
  int   got;
  int   idle;
  int   t;
  logic [7:0] obits;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_6M);
    #1;
  endtask

  task automatic push_bit(input logic b, input logic l);
    in_valid = 1'b1; in_bit = b; in_last = l;
    step();
    in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
  endtask

  task automatic load_mode(input logic [1:0] m);
    mode = m; mode_load = 1'b1;
    step();
    mode_load = 1'b0;
  endtask

  task automatic do_tick();
    sym_tick = 1'b1;
    step();
    sym_tick = 1'b0;
  endtask

  initial begin
    vecs[0] = '{mode: 2'd0, nbit: 3, bits: 8'b00000101, nsym: 3,
                syms: 9'b001_000_001, nb: 6'b01_01_01, gap: 0};
    vecs[1] = '{mode: 2'd2, nbit: 7, bits: 8'b01001011, nsym: 3,
                syms: 9'b001_001_011, nb: 6'b01_11_11, gap: GUARD_SYM + 1};
    vecs[2] = '{mode: 2'd1, nbit: 5, bits: 8'b00011110, nsym: 3,
                syms: 9'b001_011_010, nb: 6'b01_10_10, gap: 0};
    vecs[3] = '{mode: 2'd3, nbit: 2, bits: 8'b00000010, nsym: 2,
                syms: 9'b000_001_000, nb: 6'b00_01_01, gap: 0};

    rstz = 1'b0;
    step();
    step();
    check("rst in_ready", in_ready, 1);
    check("rst busy", busy, 0);
    check("rst sym_valid", sym_valid, 0);
    check("rst sym_out", sym_out, 0);
    check("rst guard_active", guard_active, 0);
    check("rst flags", {ovf, underrun, proto_err}, 0);
    rstz = 1'b1;
    step();

    for (int v = 0; v < 4; v++) begin
      load_mode(vecs[v].mode);
      for (int b = 0; b < vecs[v].nbit; b++)
        push_bit(vecs[v].bits[b], b == vecs[v].nbit - 1);
      got = 0; idle = 0; t = 0;
      while (got < vecs[v].nsym && t < 40) begin
        do_tick();
        t++;
        if (sym_valid) begin
          check($sformatf("v%0d sym%0d data", v, got), sym_out, vecs[v].syms[3*got +: 3]);
          check($sformatf("v%0d sym%0d nbits", v, got), sym_nbits, vecs[v].nb[2*got +: 2]);
          check($sformatf("v%0d sym%0d busy", v, got), busy, (got == vecs[v].nsym - 1) ? 0 : 1);
          got++;
        end else begin
          idle++;
        end
      end
      check($sformatf("v%0d symbol count", v), got, vecs[v].nsym);
      check($sformatf("v%0d idle ticks", v), idle, vecs[v].gap);
    end

    // GFSK to DQPSK switch with guard gap.
    load_mode(2'd0);
    push_bit(1, 0); push_bit(0, 0); push_bit(1, 0); push_bit(1, 0);
    load_mode(2'd1);
    push_bit(1, 0); push_bit(0, 0); push_bit(0, 0); push_bit(1, 1);
    obits = 8'b00001101;
    for (int k = 0; k < 4; k++) begin
      do_tick();
      check($sformatf("sw gfsk%0d valid", k), sym_valid, 1);
      check($sformatf("sw gfsk%0d data", k), sym_out, {2'b00, obits[k]});
    end
    do_tick();
    check("sw enter guard valid", sym_valid, 0);
    check("sw enter guard active", guard_active, 1);
    for (int k = 0; k < GUARD_SYM; k++) begin
      check($sformatf("sw guard%0d active", k), guard_active, 1);
      do_tick();
      check($sformatf("sw guard%0d valid", k), sym_valid, 0);
    end
    check("sw guard released", guard_active, 0);
    do_tick();
    check("sw dq0 valid", sym_valid, 1);
    check("sw dq0 data", sym_out, 3'b001);
    check("sw dq0 nbits", sym_nbits, 2);
    do_tick();
    check("sw dq1 valid", sym_valid, 1);
    check("sw dq1 data", sym_out, 3'b010);
    check("sw dq1 nbits", sym_nbits, 2);
    check("sw busy end", busy, 0);

    // Overflow, underrun and protocol error.
    load_mode(2'd0);
    obits = 8'b01001101;
    for (int k = 0; k < DEPTH; k++) begin
      push_bit(obits[k], 0);
      if (k == DEPTH - 2) check("ovf in_ready before full", in_ready, 1);
    end
    check("ovf in_ready full", in_ready, 0);
    push_bit(1, 0);
    check("ovf pulse", ovf, 1);
    check("ovf in_ready after drop", in_ready, 0);
    step();
    check("ovf pulse width", ovf, 0);
    for (int k = 0; k < DEPTH; k++) begin
      do_tick();
      check($sformatf("ovf out%0d valid", k), sym_valid, 1);
      check($sformatf("ovf out%0d data", k), sym_out, {2'b00, obits[k]});
    end
    do_tick();
    check("underrun pulse", underrun, 1);
    check("underrun no valid", sym_valid, 0);
    step();
    check("underrun pulse width", underrun, 0);
    mode = 2'd0; mode_load = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    step();
    mode_load = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    check("proto_err pulse", proto_err, 1);
    push_bit(0, 1);
    do_tick();
    check("proto tail valid", sym_valid, 1);
    check("proto tail data", sym_out, 0);
    check("proto tail busy", busy, 0);
    do_tick();
    check("proto bit absent", sym_valid, 0);

    // Reset mid-packet discards queued symbols.
    load_mode(2'd0);
    push_bit(1, 0); push_bit(1, 0); push_bit(1, 0);
    check("midrst busy before", busy, 1);
    rstz = 1'b0;
    step();
    rstz = 1'b1;
    check("midrst busy", busy, 0);
    check("midrst in_ready", in_ready, 1);
    check("midrst sym_valid", sym_valid, 0);
    for (int k = 0; k < 3; k++) begin
      do_tick();
      check($sformatf("midrst tick%0d valid", k), sym_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
